// File: rtl/mmio_store_unit.sv
// rtl/mmio_store_unit.sv - store decode, byte-lane enables, UART TX holding register and perf counters
// Memory-stage store side: DMEM/IMEM write enables, MMIO writes, cycle/instret counters.
module mmio_store_unit #(
   parameter int          WIDTH   = 32,
   parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             store_valid,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pc_bios,
   input  logic             instr_retire,
   input  logic             uart_tx_ready,
   output logic [3:0]       dmem_we,
   output logic [3:0]       imem_we,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             uart_tx_valid,
   output logic [7:0]       uart_tx_data,
   output logic [WIDTH-1:0] cyc_ctr,
   output logic [WIDTH-1:0] instr_ctr,
   output logic             tx_drop
);

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam logic [7:0] OFF_UART_TX = 8'h08;
   localparam logic [7:0] OFF_CTR_RST = 8'h18;

   logic [3:0]       lane_base;
   logic [3:0]       lanes;
   logic             aligned;
   logic             store_ok;
   logic [3:0]       region;
   logic             to_dmem;
   logic             to_imem;
   logic             to_mmio;
   logic             tx_store;
   logic             ctr_rst;
   logic             fire;

   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_drop_q, tx_drop_d;
   logic [WIDTH-1:0] cyc_ctr_q, cyc_ctr_d;
   logic [WIDTH-1:0] instr_ctr_q, instr_ctr_d;

   logic             unused_addr_bits;
   assign unused_addr_bits = ^addr[27:8];

   always_comb begin
      lane_base = 4'b0000;
      aligned   = 1'b0;
      mem_wdata = wdata;
      case (funct3)
         F3_SB: begin
            lane_base = 4'b0001;
            aligned   = 1'b1;
            mem_wdata = {4{wdata[7:0]}};
         end
         F3_SH: begin
            lane_base = 4'b0011;
            aligned   = ~addr[0];
            mem_wdata = {2{wdata[15:0]}};
         end
         F3_SW: begin
            lane_base = 4'b1111;
            aligned   = (addr[1:0] == 2'b00);
         end
         default: begin
            lane_base = 4'b0000;
            aligned   = 1'b0;
         end
      endcase
   end

   // Reset gates the enables combinationally so no write can slip out while rst_n is low.
   always_comb begin
      lanes    = lane_base << addr[1:0];
      store_ok = store_valid & rst_n & aligned;
      region   = addr[31:28];
      to_dmem  = (region == 4'b0001) || (region == 4'b0011);
      to_imem  = ((region == 4'b0010) || (region == 4'b0011)) && pc_bios;
      to_mmio  = (region == IO_BASE[31:28]);
      dmem_we  = (store_ok && to_dmem) ? lanes : 4'b0000;
      imem_we  = (store_ok && to_imem) ? lanes : 4'b0000;
      tx_store = store_ok && to_mmio && (addr[7:0] == OFF_UART_TX);
      ctr_rst  = store_ok && to_mmio && (addr[7:0] == OFF_CTR_RST);
      fire     = tx_valid_q & uart_tx_ready;
   end

   always_comb begin
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_drop_d  = tx_drop_q;
      if (tx_store && (!tx_valid_q || fire)) begin
         tx_valid_d = 1'b1;
         tx_data_d  = wdata[7:0];
      end else if (fire) begin
         tx_valid_d = 1'b0;
      end
      if (tx_store && tx_valid_q && !fire) begin
         tx_drop_d = 1'b1;
      end
   end

   // Counter reset overrides the increment of the same cycle.
   always_comb begin
      cyc_ctr_d   = cyc_ctr_q + 1'b1;
      instr_ctr_d = instr_ctr_q + {{(WIDTH-1){1'b0}}, instr_retire};
      if (ctr_rst) begin
         cyc_ctr_d   = '0;
         instr_ctr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_drop_q   <= 1'b0;
         cyc_ctr_q   <= '0;
         instr_ctr_q <= '0;
      end else begin
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         tx_drop_q   <= tx_drop_d;
         cyc_ctr_q   <= cyc_ctr_d;
         instr_ctr_q <= instr_ctr_d;
      end
   end

   assign uart_tx_valid = tx_valid_q;
   assign uart_tx_data  = tx_data_q;
   assign tx_drop       = tx_drop_q;
   assign cyc_ctr       = cyc_ctr_q;
   assign instr_ctr     = instr_ctr_q;

endmodule

// File: tb/tb_mmio_store_unit.sv
// tb/tb_mmio_store_unit.sv - self-checking bench for mmio_store_unit
// Directed scenarios plus randomized stores compared against a behavioural model.
module tb_mmio_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        store_valid;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        pc_bios;
   logic        instr_retire;
   logic        uart_tx_ready;
   logic [3:0]  dmem_we;
   logic [3:0]  imem_we;
   logic [31:0] mem_wdata;
   logic        uart_tx_valid;
   logic [7:0]  uart_tx_data;
   logic [31:0] cyc_ctr;
   logic [31:0] instr_ctr;
   logic        tx_drop;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_drop;
   logic [31:0] m_cyc;
   logic [31:0] m_instr;

   mmio_store_unit dut (
      .clk(clk), .rst_n(rst_n), .store_valid(store_valid), .funct3(funct3),
      .addr(addr), .wdata(wdata), .pc_bios(pc_bios), .instr_retire(instr_retire),
      .uart_tx_ready(uart_tx_ready), .dmem_we(dmem_we), .imem_we(imem_we),
      .mem_wdata(mem_wdata), .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
      .cyc_ctr(cyc_ctr), .instr_ctr(instr_ctr), .tx_drop(tx_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_drop  = 1'b0;
      m_cyc   = 32'h0;
      m_instr = 32'h0;
   endtask

   // Compare current DUT outputs with the model, then advance the model by one clock edge.
   task automatic evaluate();
      int          size;
      logic        ok, fire, tx, crst;
      logic [3:0]  reg_n, lanes;
      logic [31:0] exp_wd;
      size = (funct3 == 3'd0) ? 1 : (funct3 == 3'd1) ? 2 : (funct3 == 3'd2) ? 4 : 0;
      ok   = store_valid && (size != 0) && ((addr % size) == 0);
      reg_n = addr[31:28];
      lanes = ok ? 4'(((1 << size) - 1) << (addr % 4)) : 4'h0;
      exp_wd = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
      check("dmem_we", 32'(dmem_we), (reg_n == 4'd1 || reg_n == 4'd3) ? 32'(lanes) : 32'h0);
      check("imem_we", 32'(imem_we),
            ((reg_n == 4'd2 || reg_n == 4'd3) && pc_bios) ? 32'(lanes) : 32'h0);
      if (ok) check("mem_wdata", mem_wdata, exp_wd);
      check("tx_valid", 32'(uart_tx_valid), 32'(m_valid));
      if (m_valid) check("tx_data", 32'(uart_tx_data), 32'(m_data));
      check("tx_drop", 32'(tx_drop), 32'(m_drop));
      check("cyc_ctr", cyc_ctr, m_cyc);
      check("instr_ctr", instr_ctr, m_instr);

      tx   = ok && reg_n == 4'h8 && addr[7:0] == 8'h08;
      crst = ok && reg_n == 4'h8 && addr[7:0] == 8'h18;
      fire = m_valid && uart_tx_ready;
      if (tx && m_valid && !fire) m_drop = 1'b1;
      if (tx && (!m_valid || fire)) begin
         m_valid = 1'b1;
         m_data  = wdata[7:0];
      end else if (fire) begin
         m_valid = 1'b0;
      end
      m_cyc   = crst ? 32'h0 : m_cyc + 32'd1;
      m_instr = crst ? 32'h0 : m_instr + (instr_retire ? 32'd1 : 32'd0);
   endtask

   task automatic cycle(input logic sv, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy, input logic ret, input logic bios);
      @(negedge clk);
      store_valid   = sv;
      funct3        = f3;
      addr          = a;
      wdata         = d;
      uart_tx_ready = rdy;
      instr_retire  = ret;
      pc_bios       = bios;
      #1;
      evaluate();
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 3'd0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  regs [5];
      regs[0] = 4'h1; regs[1] = 4'h2; regs[2] = 4'h3; regs[3] = 4'h8; regs[4] = 4'h0;

      rst_n = 1'b0;
      store_valid = 1'b1; funct3 = 3'd2; addr = 32'h1000_0000; wdata = 32'hDEAD_BEEF;
      pc_bios = 1'b1; instr_retire = 1'b1; uart_tx_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dmem_we", 32'(dmem_we), 32'h0);
      check("rst_cyc", cyc_ctr, 32'h0);
      check("rst_valid", 32'(uart_tx_valid), 32'h0);
      rst_n = 1'b1;
      store_valid = 1'b0; instr_retire = 1'b0; pc_bios = 1'b0;
      #1;
      evaluate();

      // Byte, word and misaligned half stores
      cycle(1'b1, 3'd0, 32'h1000_0003, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
      check("sb_dmem", 32'(dmem_we), 32'h8);
      check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb_imem", 32'(imem_we), 32'h0);
      cycle(1'b1, 3'd2, 32'h3000_0010, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("sw_nobios_dmem", 32'(dmem_we), 32'hF);
      check("sw_nobios_imem", 32'(imem_we), 32'h0);
      cycle(1'b1, 3'd2, 32'h3000_0010, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
      check("sw_bios_dmem", 32'(dmem_we), 32'hF);
      check("sw_bios_imem", 32'(imem_we), 32'hF);
      cycle(1'b1, 3'd1, 32'h1000_0001, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1);
      check("sh_mis_dmem", 32'(dmem_we), 32'h0);

      // TX hold, drop, drain
      cycle(1'b1, 3'd2, 32'h8000_0008, 32'h41, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'd2, 32'h8000_0008, 32'h42, 1'b0, 1'b0, 1'b0);
      check("tx_load_valid", 32'(uart_tx_valid), 32'h1);
      check("tx_load_data", 32'(uart_tx_data), 32'h41);
      idle(1'b1);
      check("tx_drop_set", 32'(tx_drop), 32'h1);
      check("tx_hold_data", 32'(uart_tx_data), 32'h41);
      idle(1'b0);
      check("tx_drained", 32'(uart_tx_valid), 32'h0);

      // Store in the same cycle as fire
      cycle(1'b1, 3'd2, 32'h8000_0008, 32'h41, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'd2, 32'h8000_0008, 32'h43, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      check("tx_refill_valid", 32'(uart_tx_valid), 32'h1);
      check("tx_refill_data", 32'(uart_tx_data), 32'h43);
      check("tx_refill_drop", 32'(tx_drop), 32'h1);
      idle(1'b1);

      // Counters and software reset
      for (int i = 0; i < 100; i++) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'(i % 2), 1'b0);
      cycle(1'b1, 3'd2, 32'h8000_0018, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      check("ctr_rst_cyc", cyc_ctr, 32'h0);
      check("ctr_rst_instr", instr_ctr, 32'h0);
      idle(1'b0);
      check("ctr_resume_cyc", cyc_ctr, 32'h1);

      // Wrap from all-ones
      force dut.cyc_ctr_d = 32'hFFFF_FFFF;
      force dut.instr_ctr_d = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.cyc_ctr_d;
      release dut.instr_ctr_d;
      m_cyc = 32'hFFFF_FFFF;
      m_instr = 32'hFFFF_FFFF;
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      check("wrap_cyc", cyc_ctr, 32'h0);
      check("wrap_instr", instr_ctr, 32'h0);

      // Randomized stores
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         a[31:28] = regs[$urandom_range(0, 4)];
         if (a[31:28] == 4'h8 && $urandom_range(0, 3) != 0)
            a[7:0] = ($urandom_range(0, 3) == 0) ? 8'h18 : 8'h08;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), a, $urandom,
               1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      end

      // Asynchronous reset with a byte pending
      idle(1'b1);
      cycle(1'b1, 3'd0, 32'h8000_0008, 32'h5A, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      check("pre_rst_valid", 32'(uart_tx_valid), 32'h1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(uart_tx_valid), 32'h0);
      check("arst_data", 32'(uart_tx_data), 32'h0);
      check("arst_drop", 32'(tx_drop), 32'h0);
      check("arst_cyc", cyc_ctr, 32'h0);
      check("arst_instr", instr_ctr, 32'h0);
      store_valid = 1'b1; funct3 = 3'd2; addr = 32'h3000_0000; pc_bios = 1'b1;
      #1;
      check("arst_dmem_we", 32'(dmem_we), 32'h0);
      check("arst_imem_we", 32'(imem_we), 32'h0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      store_valid = 1'b0;
      uart_tx_ready = 1'b1;
      #1;
      evaluate();
      for (int i = 0; i < 5; i++) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
